// File: rtl/data_memory.sv
// data_memory: byte-enabled, word-organised data RAM for the north side of the CPU bus.
// Decodes its own low address window. Bus writes outside that window belong to the
// peripheral bridge and are ignored. Reads are combinational. Stores commit on the
// rising clock edge. Asserting reset asynchronously clears every word.
// Optional store logging is enabled by defining DM_WRITE_LOG_EN. When it is enabled,
// each committed store prints "@<pc>: *<word addr> <= <merged word>".
module data_memory #(
  parameter int unsigned DEPTH_WORDS = 3072,
  parameter int unsigned ADDR_BITS   = 12
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] A,
  input  logic [31:0] WD,
  input  logic [3:0]  ByteEN,
  input  logic        WE,
  input  logic [31:0] PC,
  output logic [31:0] RD
);

  localparam logic [31:0] WINDOW_BYTES = 32'(DEPTH_WORDS) << 2;

  logic [31:0]          mem [DEPTH_WORDS];
  logic                 hit;
  logic [ADDR_BITS-1:0] idx;
  logic [31:0]          cur_word;
  logic [31:0]          merged;
  logic                 commit;

  // Address decode: the window check alone excludes any index >= DEPTH_WORDS.
  always_comb begin
    hit = (A < WINDOW_BYTES);
    idx = A[ADDR_BITS+1:2];
  end

  // Combinational read, forced to zero outside the window.
  always_comb begin
    cur_word = '0;
    if (hit) cur_word = mem[idx];
    RD = cur_word;
  end

  // Byte-lane merge of write data into the currently addressed word.
  always_comb begin
    merged = cur_word;
    for (int unsigned k = 0; k < 4; k++) begin
      if (ByteEN[k]) merged[8*k +: 8] = WD[8*k +: 8];
    end
    commit = WE && hit && (ByteEN != 4'b0000);
  end

  // Storage: async clear on reset, committed stores write the merged word.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < DEPTH_WORDS; i++) mem[i] <= '0;
    end else if (commit) begin
      mem[idx] <= merged;
    end
  end

`ifdef DM_WRITE_LOG_EN
  // Store log: one line per committed store, showing the post-write word.
  always_ff @(posedge clk) begin
    if (!reset && commit)
      $display("@%h: *%h <= %h", PC, {A[31:2], 2'b00}, merged);
  end
`else
  logic unused_pc;
  assign unused_pc = ^PC;
`endif

endmodule

// File: tb/tb_data_memory.sv
// tb_data_memory: directed self-checking bench for data_memory.
module tb_data_memory;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] A;
  logic [31:0] WD;
  logic [3:0]  ByteEN;
  logic        WE;
  logic [31:0] PC;
  logic [31:0] RD;

  int unsigned errors = 0;
  int unsigned checks = 0;

  data_memory #(.DEPTH_WORDS(3072), .ADDR_BITS(12)) dut (
    .clk(clk), .reset(reset), .A(A), .WD(WD), .ByteEN(ByteEN),
    .WE(WE), .PC(PC), .RD(RD)
  );

  always #5 clk = ~clk;

  // Drive one bus write after a falling edge, let it pass a rising edge, then drop WE.
  task automatic do_write(input logic [31:0] addr, input logic [31:0] data,
                          input logic [3:0] be, input logic [31:0] pc);
    @(negedge clk);
    A = addr; WD = data; ByteEN = be; PC = pc; WE = 1'b1;
    @(posedge clk);
    #1;
    WE = 1'b0;
  endtask

  task automatic set_addr(input logic [31:0] addr);
    A = addr;
    #1;
  endtask

  task automatic test_reset;
    reset = 1'b1; WE = 1'b0; A = '0; WD = '0; ByteEN = '0; PC = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    set_addr(32'h0000_0000);
    checks++;
    if (RD !== 32'h0) begin errors++; $display("FAIL reset_rd0 actual=%h required=%h", RD, 32'h0); end
    set_addr(32'h0000_2FFC);
    checks++;
    if (RD !== 32'h0) begin errors++; $display("FAIL reset_rd_last actual=%h required=%h", RD, 32'h0); end
  endtask

  task automatic test_full_write;
    do_write(32'h10, 32'hDEADBEEF, 4'hF, 32'h3004);
    set_addr(32'h10);
    checks++;
    if (RD !== 32'hDEADBEEF) begin errors++; $display("FAIL full_write actual=%h required=%h", RD, 32'hDEADBEEF); end
  endtask

  task automatic test_byte_lanes;
    do_write(32'h12, 32'h00AB0000, 4'b0100, 32'h3008);
    set_addr(32'h10);
    checks++;
    if (RD !== 32'hDEABBEEF) begin errors++; $display("FAIL lane2_write actual=%h required=%h", RD, 32'hDEABBEEF); end
    // Pending write must not be visible before its clock edge.
    @(negedge clk);
    A = 32'h10; WD = 32'h00001234; ByteEN = 4'b0011; PC = 32'h300C; WE = 1'b1;
    #1;
    checks++;
    if (RD !== 32'hDEABBEEF) begin errors++; $display("FAIL no_bypass actual=%h required=%h", RD, 32'hDEABBEEF); end
    @(posedge clk);
    #1;
    WE = 1'b0;
    set_addr(32'h10);
    checks++;
    if (RD !== 32'hDEAB1234) begin errors++; $display("FAIL lane01_write actual=%h required=%h", RD, 32'hDEAB1234); end
  endtask

  task automatic test_peripheral_ignore;
    do_write(32'h2FFC, 32'h55AA55AA, 4'hF, 32'h3010);
    do_write(32'h7F00, 32'h11111111, 4'hF, 32'h3014);
    do_write(32'h3000, 32'h22222222, 4'hF, 32'h3018);
    // 0x4010 aliases word 0x10 in the low index bits; it must still miss.
    do_write(32'h4010, 32'h33333333, 4'hF, 32'h301C);
    set_addr(32'h7F00);
    checks++;
    if (RD !== 32'h0) begin errors++; $display("FAIL periph_7f00 actual=%h required=%h", RD, 32'h0); end
    set_addr(32'h3000);
    checks++;
    if (RD !== 32'h0) begin errors++; $display("FAIL periph_3000 actual=%h required=%h", RD, 32'h0); end
    set_addr(32'h3F00);
    checks++;
    if (RD !== 32'h0) begin errors++; $display("FAIL periph_3f00 actual=%h required=%h", RD, 32'h0); end
    set_addr(32'h4010);
    checks++;
    if (RD !== 32'h0) begin errors++; $display("FAIL periph_4010 actual=%h required=%h", RD, 32'h0); end
    set_addr(32'h2FFF);
    checks++;
    if (RD !== 32'h55AA55AA) begin errors++; $display("FAIL last_intact actual=%h required=%h", RD, 32'h55AA55AA); end
    set_addr(32'h10);
    checks++;
    if (RD !== 32'hDEAB1234) begin errors++; $display("FAIL alias_intact actual=%h required=%h", RD, 32'hDEAB1234); end
  endtask

  task automatic test_boundary;
    do_write(32'h2FFC, 32'hCAFEF00D, 4'hF, 32'h3020);
    set_addr(32'h2FFC);
    checks++;
    if (RD !== 32'hCAFEF00D) begin errors++; $display("FAIL last_word actual=%h required=%h", RD, 32'hCAFEF00D); end
    set_addr(32'h2FFD);
    checks++;
    if (RD !== 32'hCAFEF00D) begin errors++; $display("FAIL last_word_unaligned actual=%h required=%h", RD, 32'hCAFEF00D); end
  endtask

  task automatic test_async_reset;
    set_addr(32'h2FFC);
    @(negedge clk);
    #2;
    reset = 1'b1;
    #1;
    checks++;
    if (RD !== 32'h0) begin errors++; $display("FAIL async_clear actual=%h required=%h", RD, 32'h0); end
    // Writes while reset is held are blocked.
    @(negedge clk);
    A = 32'h2FFC; WD = 32'h12345678; ByteEN = 4'hF; WE = 1'b1;
    @(posedge clk);
    #1;
    WE = 1'b0;
    checks++;
    if (RD !== 32'h0) begin errors++; $display("FAIL write_in_reset actual=%h required=%h", RD, 32'h0); end
    @(negedge clk);
    reset = 1'b0;
    set_addr(32'h10);
    checks++;
    if (RD !== 32'h0) begin errors++; $display("FAIL reset_cleared_10 actual=%h required=%h", RD, 32'h0); end
  endtask

  task automatic test_zero_byteen;
    do_write(32'h20, 32'hFFFFFFFF, 4'h0, 32'h3024);
    set_addr(32'h20);
    checks++;
    if (RD !== 32'h0) begin errors++; $display("FAIL zero_byteen actual=%h required=%h", RD, 32'h0); end
    do_write(32'h20, 32'hA5A5A5A5, 4'b1001, 32'h3028);
    set_addr(32'h20);
    checks++;
    if (RD !== 32'hA50000A5) begin errors++; $display("FAIL post_reset_write actual=%h required=%h", RD, 32'hA50000A5); end
  endtask

  initial begin
    test_reset();
    test_full_write();
    test_byte_lanes();
    test_peripheral_ignore();
    test_boundary();
    test_async_reset();
    test_zero_byteen();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
